// File: rtl/instr_decode_cond_if.sv
// ============================================================================
// Module : instr_decode_cond_if
// Brief  : Fetch handshake, flag write and decode bundle for instr_decode_cond.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_decode_cond_if;
  logic        fetch_start;
  logic        mem_req;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        ir_loaded;
  logic        flag_we;
  logic [3:0]  flags_in;
  logic [3:0]  flags;
  logic [31:0] ir;
  logic [15:0] family_bits;
  logic        COND;
  logic        L;
  logic        P;
  logic        A;

  // Control store / memory side
  modport master (
    output fetch_start, mem_valid, mem_rdata, flag_we, flags_in,
    input  mem_req, busy, ir_loaded, flags, ir, family_bits, COND, L, P, A
  );

  // Decoder side
  modport slave (
    input  fetch_start, mem_valid, mem_rdata, flag_we, flags_in,
    output mem_req, busy, ir_loaded, flags, ir, family_bits, COND, L, P, A
  );
endinterface

`default_nettype wire

// File: rtl/instr_decode_cond.sv
// ============================================================================
// Module : instr_decode_cond
// Brief  : Instruction fetch FSM, IR / NZCV registers and decode outputs
//          (one-hot family, condition pass, L/P/A) for the microsequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_decode_cond #(
  parameter logic [31:0] RESET_IR = 32'hE1A00000,
  parameter bit          NV_NEVER = 1'b1
) (
  input  wire              clk,
  input  wire              rst_n,
  instr_decode_cond_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;
  logic        ir_loaded_q, ir_loaded_d;
  logic [3:0]  fam_w;
  logic        cond_w;

  // State, IR, flags and load pulse registers; reset aborts any fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ir_q        <= RESET_IR;
      flags_q     <= 4'b0000;
      ir_loaded_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      flags_q     <= flags_d;
      ir_loaded_q <= ir_loaded_d;
    end
  end

  // Next state and handshake outputs; mem_valid only matters in FETCH
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    ir_loaded_d = 1'b0;
    bus.mem_req = 1'b0;
    bus.busy    = 1'b0;
    flags_d     = bus.flag_we ? bus.flags_in : flags_q;
    case (state_q)
      S_IDLE: begin
        if (bus.fetch_start) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.busy    = 1'b1;
        if (bus.mem_valid) begin
          ir_d        = bus.mem_rdata;
          ir_loaded_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Instruction family number, first matching rule wins
  always_comb begin
    fam_w = 4'd15;
    case (ir_q[27:25])
      3'b000: begin
        if (ir_q[7:4] == 4'b1001) begin
          if (ir_q[24:23] == 2'b00)                                fam_w = 4'd3;
          else if (ir_q[24:23] == 2'b01)                           fam_w = 4'd4;
          else if (ir_q[24:23] == 2'b10 && ir_q[21:20] == 2'b00)   fam_w = 4'd5;
          else                                                     fam_w = 4'd15;
        end else if (ir_q[7] && ir_q[4]) begin
          fam_w = 4'd6;
        end else if (ir_q[27:4] == 24'h12FFF1) begin
          fam_w = 4'd14;
        end else if (ir_q[24:23] == 2'b10 && !ir_q[20]) begin
          fam_w = ir_q[21] ? 4'd13 : 4'd12;
        end else begin
          fam_w = ir_q[4] ? 4'd1 : 4'd0;
        end
      end
      3'b001: begin
        if (ir_q[24:23] == 2'b10 && !ir_q[20]) fam_w = ir_q[21] ? 4'd13 : 4'd15;
        else                                   fam_w = 4'd2;
      end
      3'b010:  fam_w = 4'd7;
      3'b011:  fam_w = ir_q[4] ? 4'd15 : 4'd8;
      3'b100:  fam_w = 4'd9;
      3'b101:  fam_w = 4'd10;
      3'b110:  fam_w = 4'd15;
      default: fam_w = ir_q[24] ? 4'd11 : 4'd15;
    endcase
  end

  // Condition pass from registered NZCV = {N,Z,C,V}
  always_comb begin
    cond_w = 1'b1;
    case (ir_q[31:28])
      4'h0: cond_w = flags_q[2];
      4'h1: cond_w = !flags_q[2];
      4'h2: cond_w = flags_q[1];
      4'h3: cond_w = !flags_q[1];
      4'h4: cond_w = flags_q[3];
      4'h5: cond_w = !flags_q[3];
      4'h6: cond_w = flags_q[0];
      4'h7: cond_w = !flags_q[0];
      4'h8: cond_w = flags_q[1] && !flags_q[2];
      4'h9: cond_w = !flags_q[1] || flags_q[2];
      4'hA: cond_w = (flags_q[3] == flags_q[0]);
      4'hB: cond_w = (flags_q[3] != flags_q[0]);
      4'hC: cond_w = !flags_q[2] && (flags_q[3] == flags_q[0]);
      4'hD: cond_w = flags_q[2] || (flags_q[3] != flags_q[0]);
      4'hE: cond_w = 1'b1;
      default: cond_w = !NV_NEVER;
    endcase
  end

  assign bus.ir          = ir_q;
  assign bus.flags       = flags_q;
  assign bus.ir_loaded   = ir_loaded_q;
  assign bus.family_bits = 16'd1 << fam_w;
  assign bus.COND        = cond_w;
  assign bus.L           = ir_q[20];
  assign bus.P           = ir_q[24];
  assign bus.A           = ir_q[21];

endmodule

`default_nettype wire

// File: doc/instr_decode_cond.md
Name: instr_decode_cond

Overview:
- Upstream neighbour of the microcoded control-store sequencer.
- Runs the instruction-fetch handshake with memory and holds the Instruction Register (IR) and the NZCV flag register.
- Presents the sequencer's decode inputs: a one-hot 16-bit instruction family, the condition-pass bit COND, and the L/P/A modifier bits.
- The sequencer converts `family_bits` to a 4-bit family number and dispatches to microcode address family×8.

Parameters:
- RESET_IR, 32'hE1A00000, IR value after reset (MOV r0,r0, cond AL).
- NV_NEVER, 1, 1 = cond 4'b1111 fails; 0 = cond 4'b1111 passes.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- rst, input, 1, asynchronous, active-low reset.
- fetch_start, input, 1, one-cycle fetch request from the control store.
- mem_req, output, 1, instruction read request to memory.
- mem_valid, input, 1, memory returns `mem_rdata` this cycle.
- mem_rdata, input, 32, instruction word.
- busy, output, 1, fetch in progress.
- ir_loaded, output, 1, one-cycle pulse the cycle after the IR updates.
- flag_we, input, 1, NZCV write enable.
- flags_in, input, 4, new {N,Z,C,V}.
- flags, output, 4, registered NZCV.
- ir, output, 32, registered IR.
- family_bits, output, 16, one-hot family, combinational from `ir`.
- COND, output, 1, condition pass, combinational from `ir[31:28]` and `flags`.
- L, output, 1, `ir[20]`.
- P, output, 1, `ir[24]`.
- A, output, 1, `ir[21]`.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - FSM goes to IDLE; `ir` = RESET_IR; `flags` = 4'b0000.
  - `mem_req` = 0; `busy` = 0; `ir_loaded` = 0.
  - Decode outputs follow from RESET_IR: `family_bits` = 16'h0001, COND = 1.
  - Reset asserted mid-fetch aborts the fetch. A `mem_valid` arriving after release while in IDLE is ignored.
- FSM, two states:
  - IDLE: `fetch_start`=1 → FETCH.
  - FETCH: `mem_req` = `busy` = 1. On `mem_valid`=1: `ir` ← `mem_rdata`, → IDLE, `ir_loaded` = 1 in the following cycle.
  - `mem_valid` is sampled only in FETCH, so the earliest IR load is the cycle after `fetch_start`.
  - `fetch_start` during FETCH is ignored; no queueing.
  - `mem_valid` in IDLE is ignored.
- Flags:
  - `flag_we` updates `flags` at posedge, in either FSM state.
  - COND always uses the registered `flags`; a write in cycle t affects COND from t+1.
  - A simultaneous IR load and flag write both take effect.
- COND on `ir[31:28]`:
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C. 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z. A GE: N==V. B LT: N!=V. C GT: !Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F: !NV_NEVER.
- Family, first match wins; exactly one bit of `family_bits` is set:
  - `ir[27:25]`=000:
    - `ir[7:4]`=1001:
      - `ir[24:23]`=00 → 3 MUL/MLA.
      - 01 → 4 multiply-long.
      - 10 with `ir[21:20]`=00 → 5 SWP.
      - otherwise → 15.
    - Else `ir[7]`&`ir[4]` → 6 halfword/signed transfer.
    - Else `ir[27:4]`=24'h12FFF1 → 14 BX.
    - Else `ir[24:23]`=10 & !`ir[20]` → 13 MSR if `ir[21]`, else 12 MRS.
    - Else `ir[4]`=0 → 0 DP shift-imm.
    - Else → 1 DP shift-reg.
  - 001: `ir[24:23]`=10 & !`ir[20]` → 13 if `ir[21]`, else 15. Otherwise → 2 DP immediate.
  - 010 → 7 LDR/STR immediate offset.
  - 011 → 15 if `ir[4]`, else 8 LDR/STR register offset.
  - 100 → 9 LDM/STM.
  - 101 → 10 B/BL.
  - 110 → 15 (coprocessor, undefined).
  - 111 → 11 SWI if `ir[24]`, else 15.
- L/P/A are raw IR bits regardless of family; the microcode chooses whether to use them.

Test Plan:
- Reset:
  - Drive `rst` low mid-FETCH with `mem_req`=1.
  - Required: `mem_req`=0 immediately (async); `ir`=E1A00000; `family_bits`=0001; COND=1; `flags`=0.
- Fetch handshake:
  - `fetch_start` at t0; `mem_valid` with E0810002 at t3.
  - Required: `mem_req`=1 at t1–t3; `ir`=E0810002 and `ir_loaded`=1 at t4; `family_bits`=0001.
  - A second `fetch_start` at t2 and a `mem_valid` in IDLE at t6 both cause no change.
- Family sweep:
  - Load E0000291 → bit 3.
  - E12FFF1E → bit 14.
  - E1B000B0 → bit 6.
  - E59F1004 → bit 7; L=1, P=1.
  - EAFFFFFE → bit 10.
  - EF000000 → bit 11.
  - E6000010 → bit 15.
  - E10F0000 → bit 12.
- Condition table:
  - For all 16 values of `ir[31:28]` × 16 flag values, COND matches the table; cond F gives COND=0.
  - Repeat with NV_NEVER=0; cond F then gives 1.
- Flag timing:
  - `ir`=0A000000 (BEQ), `flags`=0000, `flag_we` with 0100 at t0.
  - Required: COND=0 at t0, COND=1 at t1.
  - Simultaneous `flag_we` and IR load: both visible the next cycle.
